alu_arbiter: RTL
================

// Module: alu_arbiter
// PURPOSE
//  Shares one combinational 8-bit ALU between two requesters. Each requester
//  issues (A, B, ALU_Sel) over a valid/ready handshake. The block arbitrates,
//  drives the shared ALU and registers its result into a one-entry response slot.
//  The response carries the winner's ID and uses its own valid/ready handshake.
//  Sits between the ALU datapath and its clients (sequencers, test drivers).
// PARAMETERS
//  DATA_W         8   operand/result width; must match the alu instance
//  SEL_W          4   ALU_Sel width (16 opcodes)
//  PRIORITY_MODE  0   0 = round-robin; 1 = fixed priority, req0 always wins
//  CNT_W          16  width of per-requester grant counters
// PORTS
//  clk          in   1        rising-edge clock
//  rst          in   1        synchronous, active-high reset
//  req0_valid   in   1        requester 0 has an operation
//  req0_ready   out  1        requester 0 operation accepted this cycle
//  req0_a       in   DATA_W   requester 0 operand A
//  req0_b       in   DATA_W   requester 0 operand B
//  req0_sel     in   SEL_W    requester 0 ALU opcode
//  req1_valid   in   1        requester 1 has an operation
//  req1_ready   out  1        requester 1 operation accepted this cycle
//  req1_a       in   DATA_W   requester 1 operand A
//  req1_b       in   DATA_W   requester 1 operand B
//  req1_sel     in   SEL_W    requester 1 ALU opcode
//  rsp_valid    out  1        response slot holds a result
//  rsp_ready    in   1        consumer takes the response
//  rsp_data     out  DATA_W   registered ALU_Out
//  rsp_carry    out  1        registered CarryOut
//  rsp_id       out  1        ID of the requester that produced rsp_data
//  gnt_cnt0     out  CNT_W    saturating count of requester-0 accepts
//  gnt_cnt1     out  CNT_W    saturating count of requester-1 accepts
// BEHAVIOUR
//  - Reset values:
//      rsp_valid=0, rsp_data=0, rsp_carry=0, rsp_id=0, gnt_cnt0/1=0.
//      last_grant=1, so req0 wins the first contention.
//  - Slot states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
//  - can_accept = !rsp_valid | rsp_ready.
//  - Grant (combinational, from valids and last_grant only):
//      only one valid -> that requester.
//      both valid, RR -> requester != last_grant.
//      both valid, PRIORITY_MODE=1 -> req0.
//  - reqN_ready = can_accept & grantN. Ready never depends on the requester's own ready.
//  - Accept (valid & ready) in cycle N:
//      winner's operands/opcode muxed into the shared alu.
//      ALU_Out/CarryOut/ID captured into the slot at edge N+1; rsp_valid=1.
//      last_grant <= winner; gnt_cntN increments, holding at 2^CNT_W-1.
//      Latency accept -> rsp_valid is 1 cycle.
//  - FULL with rsp_ready=0:
//      rsp_data/carry/id held stable; both ready outputs 0.
//  - FULL with rsp_ready=1 and a valid request:
//      new result overwrites the slot in the same edge (back-to-back, no bubble).
//  - FULL with rsp_ready=1 and no request: slot goes EMPTY.
//  - Requesters must hold a/b/sel stable while valid & !ready.
//      Deasserting valid before ready is permitted; that request is simply never granted.
//  - Arithmetic follows the alu instance; carry is meaningful only for add.
//      Other ops' carry is passed through unmodified.
//  - rst asserted mid-operation:
//      pending response discarded; all state returns to reset values next edge.
//      No ready is asserted while rst=1.
// STRUCTURE
//  - Shared package alu_pkg: opcode constants (ALU_ADD=4'h0 ... ALU_EQ=4'hF).
//    The package also holds the DATA_W/SEL_W defaults.
//  - One sub-module: the existing combinational alu, instantiated once.
//    Arbiter, slot register and counters are local logic.
// TESTING
//  1. Single request:
//     req0 A=0x0A B=0x02 sel=ADD, rsp_ready=1 ->
//     next cycle rsp_valid=1, data=0x0C, carry=0, id=0, gnt_cnt0=1.
//  2. Carry:
//     req1 A=0xF6 B=0x0A sel=ADD -> data=0x00, carry=1, id=1.
//  3. Contention, RR:
//     both valid continuously, rsp_ready=1 ->
//     ids 0,1,0,1... one result per cycle; counters equal after 8 cycles.
//  4. Backpressure:
//     slot FULL, rsp_ready=0 for 3 cycles ->
//     both ready=0 and rsp fields unchanged. Release -> next result follows with no bubble.
//  5. PRIORITY_MODE=1:
//     both valid for 4 cycles -> all ids 0; req1 granted only once req0_valid drops.
//  6. Reset while FULL ->
//     rsp_valid=0 and counters 0 after the edge; first contention then grants req0.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared opcode constants, width defaults and response slot
//                state type for the shared-ALU arbiter slice.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int SEL_W_DEF  = 4;
   localparam int CNT_W_DEF  = 16;

   localparam logic [3:0] ALU_ADD  = 4'h0;
   localparam logic [3:0] ALU_SUB  = 4'h1;
   localparam logic [3:0] ALU_MUL  = 4'h2;
   localparam logic [3:0] ALU_DIV  = 4'h3;
   localparam logic [3:0] ALU_SHL  = 4'h4;
   localparam logic [3:0] ALU_SHR  = 4'h5;
   localparam logic [3:0] ALU_ROL  = 4'h6;
   localparam logic [3:0] ALU_ROR  = 4'h7;
   localparam logic [3:0] ALU_AND  = 4'h8;
   localparam logic [3:0] ALU_OR   = 4'h9;
   localparam logic [3:0] ALU_XOR  = 4'hA;
   localparam logic [3:0] ALU_NOR  = 4'hB;
   localparam logic [3:0] ALU_NAND = 4'hC;
   localparam logic [3:0] ALU_XNOR = 4'hD;
   localparam logic [3:0] ALU_GT   = 4'hE;
   localparam logic [3:0] ALU_EQ   = 4'hF;

   // One-entry response slot: EMPTY means rsp_valid is low.
   typedef enum logic [0:0] {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter_if
//  Description : Two request channels, one response channel and the grant
//                counters of the shared-ALU arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_arbiter_if
   import alu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int SEL_W  = SEL_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
);
   logic              req0_valid;
   logic              req0_ready;
   logic [DATA_W-1:0] req0_a;
   logic [DATA_W-1:0] req0_b;
   logic [SEL_W-1:0]  req0_sel;

   logic              req1_valid;
   logic              req1_ready;
   logic [DATA_W-1:0] req1_a;
   logic [DATA_W-1:0] req1_b;
   logic [SEL_W-1:0]  req1_sel;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_carry;
   logic              rsp_id;

   logic [CNT_W-1:0]  gnt_cnt0;
   logic [CNT_W-1:0]  gnt_cnt1;

   // Requesters and response consumer
   modport master (
      output req0_valid, req0_a, req0_b, req0_sel,
      output req1_valid, req1_a, req1_b, req1_sel,
      output rsp_ready,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_data, rsp_carry, rsp_id,
      input  gnt_cnt0, gnt_cnt1
   );

   // Arbiter side
   modport slave (
      input  req0_valid, req0_a, req0_b, req0_sel,
      input  req1_valid, req1_a, req1_b, req1_sel,
      input  rsp_ready,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_data, rsp_carry, rsp_id,
      output gnt_cnt0, gnt_cnt1
   );
endinterface
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
//  Module      : alu
//  Description : Combinational 16-opcode ALU. CarryOut is always the carry
//                of A+B, whatever the opcode.
//  Revision    : 1.0  initial release
// ============================================================================
module alu
   import alu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int SEL_W  = SEL_W_DEF
) (
   input  wire logic [DATA_W-1:0] a_i,
   input  wire logic [DATA_W-1:0] b_i,
   input  wire logic [SEL_W-1:0]  sel_i,
   output logic      [DATA_W-1:0] result_o,
   output logic                   carry_o
);

   logic [DATA_W:0] sum;

   // Add carry is independent of the opcode
   always_comb begin
      sum     = {1'b0, a_i} + {1'b0, b_i};
      carry_o = sum[DATA_W];
   end

   // Opcode decode; divide by zero returns all ones so the result is defined
   always_comb begin
      result_o = '0;
      case (sel_i)
         ALU_ADD:  result_o = sum[DATA_W-1:0];
         ALU_SUB:  result_o = a_i - b_i;
         ALU_MUL:  result_o = a_i * b_i;
         ALU_DIV:  result_o = (b_i == '0) ? '1 : a_i / b_i;
         ALU_SHL:  result_o = a_i << 1;
         ALU_SHR:  result_o = a_i >> 1;
         ALU_ROL:  result_o = {a_i[DATA_W-2:0], a_i[DATA_W-1]};
         ALU_ROR:  result_o = {a_i[0], a_i[DATA_W-1:1]};
         ALU_AND:  result_o = a_i & b_i;
         ALU_OR:   result_o = a_i | b_i;
         ALU_XOR:  result_o = a_i ^ b_i;
         ALU_NOR:  result_o = ~(a_i | b_i);
         ALU_NAND: result_o = ~(a_i & b_i);
         ALU_XNOR: result_o = ~(a_i ^ b_i);
         ALU_GT:   result_o = {{(DATA_W-1){1'b0}}, (a_i > b_i)};
         ALU_EQ:   result_o = {{(DATA_W-1){1'b0}}, (a_i == b_i)};
         default:  result_o = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Arbitrates two requesters onto one shared ALU and registers
//                the winner's result and ID into a one-entry response slot.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int DATA_W        = DATA_W_DEF,
   parameter int SEL_W         = SEL_W_DEF,
   parameter int PRIORITY_MODE = 0,
   parameter int CNT_W         = CNT_W_DEF
) (
   input wire logic     clk,
   input wire logic     rst,
   alu_arbiter_if.slave bus
);

   slot_state_t       state_q, state_d;
   logic [DATA_W-1:0] data_q,  data_d;
   logic              carry_q, carry_d;
   logic              id_q,    id_d;
   logic              last_q,  last_d;
   logic [CNT_W-1:0]  cnt0_q,  cnt0_d;
   logic [CNT_W-1:0]  cnt1_q,  cnt1_d;

   logic              can_accept;
   logic              win_id;
   logic              ready0;
   logic              ready1;
   logic              accept0;
   logic              accept1;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [SEL_W-1:0]  alu_sel;
   logic [DATA_W-1:0] alu_out;
   logic              alu_carry;

   // Pick a winner from the valids and the last grant; gate readies by slot space
   always_comb begin
      win_id = 1'b0;
      if (bus.req0_valid && bus.req1_valid) begin
         win_id = (PRIORITY_MODE != 0) ? 1'b0 : ~last_q;
      end else if (bus.req1_valid) begin
         win_id = 1'b1;
      end
      can_accept = (state_q == SLOT_EMPTY) || bus.rsp_ready;
      ready0     = ~rst & can_accept & bus.req0_valid & ~win_id;
      ready1     = ~rst & can_accept & bus.req1_valid &  win_id;
      accept0    = bus.req0_valid & ready0;
      accept1    = bus.req1_valid & ready1;
   end

   // Steer the winner's operation into the shared ALU
   always_comb begin
      alu_a   = win_id ? bus.req1_a   : bus.req0_a;
      alu_b   = win_id ? bus.req1_b   : bus.req0_b;
      alu_sel = win_id ? bus.req1_sel : bus.req0_sel;
   end

   alu #(
      .DATA_W (DATA_W),
      .SEL_W  (SEL_W)
   ) u_alu (
      .a_i      (alu_a),
      .b_i      (alu_b),
      .sel_i    (alu_sel),
      .result_o (alu_out),
      .carry_o  (alu_carry)
   );

   // Slot next state: an accept overwrites the slot even while it is draining
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      carry_d = carry_q;
      id_d    = id_q;
      last_d  = last_q;
      cnt0_d  = cnt0_q;
      cnt1_d  = cnt1_q;
      if (accept0 || accept1) begin
         state_d = SLOT_FULL;
         data_d  = alu_out;
         carry_d = alu_carry;
         id_d    = win_id;
         last_d  = win_id;
      end else if (bus.rsp_ready) begin
         state_d = SLOT_EMPTY;
      end
      if (accept0 && (cnt0_q != '1)) cnt0_d = cnt0_q + CNT_W'(1);
      if (accept1 && (cnt1_q != '1)) cnt1_d = cnt1_q + CNT_W'(1);
   end

   // State register; last grant resets to 1 so req0 wins the first contention
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SLOT_EMPTY;
         data_q  <= '0;
         carry_q <= 1'b0;
         id_q    <= 1'b0;
         last_q  <= 1'b1;
         cnt0_q  <= '0;
         cnt1_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         carry_q <= carry_d;
         id_q    <= id_d;
         last_q  <= last_d;
         cnt0_q  <= cnt0_d;
         cnt1_q  <= cnt1_d;
      end
   end

   assign bus.req0_ready = ready0;
   assign bus.req1_ready = ready1;
   assign bus.rsp_valid  = (state_q == SLOT_FULL);
   assign bus.rsp_data   = data_q;
   assign bus.rsp_carry  = carry_q;
   assign bus.rsp_id     = id_q;
   assign bus.gnt_cnt0   = cnt0_q;
   assign bus.gnt_cnt1   = cnt1_q;

endmodule
`default_nettype wire
